// File: rtl/ti_share_recombiner.sv
// ti_share_recombiner: collects three serial TI output shares, XORs them into the
// unmasked byte and queues the result in a small FIFO with valid/ready output.
module ti_share_recombiner #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] share_in,
    input  logic       share_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_err,
    output logic [7:0] frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, GOT1, GOT2} state_t;

    state_t        state, state_nxt;
    logic [7:0]    acc, acc_nxt, push_data, head_nxt;
    logic          push, trunc, full, pop, wr_en, drop;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]   count;
    logic [7:0]    mem [DEPTH];

    always_comb begin
        state_nxt = IDLE;
        acc_nxt   = 8'h00;
        push      = 1'b0;
        trunc     = 1'b0;
        push_data = acc ^ share_in;
        case (state)
            IDLE: if (share_valid) begin
                state_nxt = GOT1;
                acc_nxt   = share_in;
            end
            GOT1: if (share_valid) begin
                state_nxt = GOT2;
                acc_nxt   = acc ^ share_in;
            end else trunc = 1'b1;
            GOT2: if (share_valid) push = 1'b1;
                  else trunc = 1'b1;
            default: ;
        endcase
    end

    assign data_valid = count != '0;
    assign full       = count == FULL_LVL;
    assign pop        = data_valid & data_ready;
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign rd_nxt     = pop ? rd_ptr + 1'b1 : rd_ptr;
    // the new head may be the byte being written on this same edge
    assign head_nxt   = (wr_en && wr_ptr == rd_nxt) ? push_data : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= 8'h00;
            frame_err <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            data_out  <= 8'h00;
            overflow  <= 1'b0;
            frame_cnt <= 8'h00;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            frame_err <= trunc;
            rd_ptr    <= rd_nxt;
            count     <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (wr_en) frame_cnt <= frame_cnt + 8'd1;
            if (wr_en || pop) data_out <= head_nxt;
            if (drop) overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end
endmodule
